// File: rtl/audio_voice_sequencer_if.sv
// Handshake and attribute-RAM bus of the voice sequencer.
// master = sequencer side, slave = driver/consumer side.
interface audio_voice_sequencer_if #(
  parameter int PHASE_W = 17
);
  logic               start_i;
  logic               busy_o;
  logic               ram_rd_en_o;
  logic [3:0]         ram_rd_addr_o;
  logic [31:0]        ram_rd_data_i;
  logic               voice_valid_o;
  logic               voice_ready_i;
  logic [3:0]         voice_idx_o;
  logic [PHASE_W-1:0] voice_phase_o;
  logic [5:0]         voice_vol_o;
  logic [1:0]         voice_lr_o;
  logic [1:0]         voice_wave_o;
  logic [5:0]         voice_pw_o;
  logic               frame_done_o;
  logic               overrun_o;

  modport master (
    input  start_i, ram_rd_data_i, voice_ready_i,
    output busy_o, ram_rd_en_o, ram_rd_addr_o, voice_valid_o, voice_idx_o,
           voice_phase_o, voice_vol_o, voice_lr_o, voice_wave_o, voice_pw_o,
           frame_done_o, overrun_o
  );

  modport slave (
    output start_i, ram_rd_data_i, voice_ready_i,
    input  busy_o, ram_rd_en_o, ram_rd_addr_o, voice_valid_o, voice_idx_o,
           voice_phase_o, voice_vol_o, voice_lr_o, voice_wave_o, voice_pw_o,
           frame_done_o, overrun_o
  );
endinterface

// File: rtl/audio_voice_sequencer.sv
// 16-voice frame sequencer: reads each attribute word, advances that voice's phase, presents the result.
// Optional AUDIO_SEQ_SKIP_MUTED_EN: voices with vol=0 still advance phase but are not emitted.
module audio_voice_sequencer #(
  parameter int PHASE_W = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  audio_voice_sequencer_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [PHASE_W-1:0] r_phase [16];
  logic [PHASE_W-1:0] r_phase_out;
  logic [5:0]         r_vol;
  logic [1:0]         r_lr;
  logic [1:0]         r_wave;
  logic [5:0]         r_pw;
  logic               r_overrun;

  logic [PHASE_W-1:0] w_phase_nxt;
  logic               w_hs;
  logic               w_skip;
  logic               w_done;

  assign w_phase_nxt = r_phase[r_cnt] + PHASE_W'(bus.ram_rd_data_i[15:0]);
  assign w_hs        = (r_state == S_EMIT) && bus.voice_ready_i;
`ifdef AUDIO_SEQ_SKIP_MUTED_EN
  assign w_skip      = (r_state == S_WAIT) && (bus.ram_rd_data_i[21:16] == 6'd0);
`else
  assign w_skip      = 1'b0;
`endif
  // Frame ends on the last voice's handshake, or on its WAIT when that voice is skipped.
  assign w_done      = (w_hs || w_skip) && (r_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase_out <= '0;
      r_vol       <= '0;
      r_lr        <= '0;
      r_wave      <= '0;
      r_pw        <= '0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < 16; i++) r_phase[i] <= '0;
    end else begin
      // Any start outside IDLE, including the final handshake cycle, is an overrun.
      r_overrun <= bus.start_i && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_state <= S_READ;
          r_cnt   <= '0;
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_phase[r_cnt] <= w_phase_nxt;
          r_phase_out    <= w_phase_nxt;
          r_vol          <= bus.ram_rd_data_i[21:16];
          r_lr           <= bus.ram_rd_data_i[23:22];
          r_pw           <= bus.ram_rd_data_i[29:24];
          r_wave         <= bus.ram_rd_data_i[31:30];
          if (!w_skip)           r_state <= S_EMIT;
          else if (w_done)       r_state <= S_IDLE;
          else begin
            r_state <= S_READ;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        default: if (w_hs) begin
          if (w_done) r_state <= S_IDLE;
          else begin
            r_state <= S_READ;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.ram_rd_en_o   = (r_state == S_READ);
  assign bus.ram_rd_addr_o = r_cnt;
  assign bus.voice_valid_o = (r_state == S_EMIT);
  assign bus.voice_idx_o   = r_cnt;
  assign bus.voice_phase_o = r_phase_out;
  assign bus.voice_vol_o   = r_vol;
  assign bus.voice_lr_o    = r_lr;
  assign bus.voice_wave_o  = r_wave;
  assign bus.voice_pw_o    = r_pw;
  assign bus.frame_done_o  = w_done;
  assign bus.overrun_o     = r_overrun;
endmodule

// File: tb/tb_audio_voice_sequencer.sv
// Scoreboard bench for audio_voice_sequencer: expected voice results are queued at frame start
// and popped by a negedge monitor on every handshake.
module tb_audio_voice_sequencer;
  localparam int PHASE_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_voice_sequencer_if #(.PHASE_W(PHASE_W)) bus();
  audio_voice_sequencer #(.PHASE_W(PHASE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]         idx;
    logic [PHASE_W-1:0] phase;
    logic [5:0]         vol;
    logic [1:0]         lr;
    logic [1:0]         wave;
    logic [5:0]         pw;
  } exp_t;

  exp_t               sb[$];
  logic [31:0]        attr [16];
  logic [PHASE_W-1:0] mph  [16];
  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, ovr_cnt = 0, ovr_cyc = 0, hs_cnt = 0, stall_cnt = 0;
  int t0, exp_len, exp_hs, done0, hs0, stall0;
  logic [PHASE_W-1:0] v0_phase, v5_phase;
  logic held = 1'b0;
  exp_t held_val;

  always @(posedge clk) cyc <= cyc + 1;
  // Attribute RAM: data valid only in the cycle after the request.
  always @(posedge clk) bus.ram_rd_data_i <= bus.ram_rd_en_o ? attr[bus.ram_rd_addr_o] : 32'hDEAD_BEEF;

  function automatic exp_t cur_out();
    exp_t e;
    e.idx = bus.voice_idx_o;  e.phase = bus.voice_phase_o; e.vol = bus.voice_vol_o;
    e.lr  = bus.voice_lr_o;   e.wave  = bus.voice_wave_o;  e.pw  = bus.voice_pw_o;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t got, e;
    got = cur_out();
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        vectors++;
        if (!bus.voice_valid_o || got !== held_val) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%0b %h required valid=1 %h", bus.voice_valid_o, got, held_val);
        end
      end
      held = bus.voice_valid_o && !bus.voice_ready_i;
      held_val = got;
      if (held) stall_cnt++;
      if (bus.frame_done_o) begin done_cnt++; done_cyc = cyc; end
      if (bus.overrun_o) begin ovr_cnt++; ovr_cyc = cyc; end
      if (bus.voice_valid_o && bus.voice_ready_i) begin
        hs_cnt++;
        vectors++;
        if (got.idx == 4'd0) v0_phase = got.phase;
        if (got.idx == 4'd5) v5_phase = got.phase;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL voice_unexpected: got %h required no handshake", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL voice_out: got %h required %h", got, e);
          end
        end
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    for (int v = 0; v < 16; v++) mph[v] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start_i = 1'b0; bus.voice_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
  endtask

  task automatic start_frame();
    exp_t e;
    logic muted;
    exp_len = 0; exp_hs = 0;
    for (int v = 0; v < 16; v++) begin
      mph[v] = mph[v] + PHASE_W'(attr[v][15:0]);
      muted = 1'b0;
`ifdef AUDIO_SEQ_SKIP_MUTED_EN
      muted = (attr[v][21:16] == 6'd0);
`endif
      if (!muted) begin
        e.idx = 4'(v); e.phase = mph[v]; e.vol = attr[v][21:16];
        e.lr = attr[v][23:22]; e.pw = attr[v][29:24]; e.wave = attr[v][31:30];
        sb.push_back(e);
        exp_hs++;
      end
      exp_len += muted ? 2 : 3;
    end
    done0 = done_cnt; hs0 = hs_cnt; stall0 = stall_cnt;
    @(posedge clk); #1 bus.start_i = 1'b1; t0 = cyc;
    @(posedge clk); #1 bus.start_i = 1'b0;
  endtask

  task automatic finish_frame(input bit rnd);
    int n = 0;
    while (done_cnt == done0 && n < 1000) begin
      @(posedge clk); #1 n++;
      if (rnd) bus.voice_ready_i = 1'($urandom_range(0, 1));
    end
    bus.voice_ready_i = 1'b1;
    vectors++;
    if (done_cnt == done0) begin
      miscompares++; $display("FAIL frame_timeout: got no frame_done after %0d cycles required one", n);
    end
    vectors++;
    if (done_cyc - t0 != exp_len + stall_cnt - stall0) begin
      miscompares++;
      $display("FAIL frame_len: got %0d required %0d", done_cyc - t0, exp_len + stall_cnt - stall0);
    end
    vectors++;
    if (hs_cnt - hs0 != exp_hs) begin
      miscompares++; $display("FAIL handshakes: got %0d required %0d", hs_cnt - hs0, exp_hs);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1 vectors++;
    if (done_cnt - done0 != 1 || bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_end: got done=%0d busy=%0b required done=1 busy=0", done_cnt - done0, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start_i = 1'b1; bus.voice_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 vectors++;
    if ({bus.busy_o, bus.voice_valid_o, bus.ram_rd_en_o, bus.frame_done_o, bus.overrun_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.busy_o, bus.voice_valid_o, bus.ram_rd_en_o, bus.frame_done_o, bus.overrun_o});
    end
    vectors++;
    if ({bus.ram_rd_addr_o, cur_out()} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h required 0", {bus.ram_rd_addr_o, cur_out()});
    end
    rst = 1'b0; bus.start_i = 1'b0;
    @(posedge clk); #1 vectors++;
    if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start: got busy=%0b ovr=%0b required 0 0", bus.busy_o, bus.overrun_o);
    end
    clear_model();
  endtask

  task automatic test_basic();
    do_reset();
    for (int v = 0; v < 16; v++) attr[v] = 32'h0000_0100;
    for (int f = 1; f <= 3; f++) begin
      start_frame();
      finish_frame(1'b0);
`ifndef AUDIO_SEQ_SKIP_MUTED_EN
      vectors++;
      if (v0_phase !== PHASE_W'(256 * f)) begin
        miscompares++; $display("FAIL basic_phase: got %0d required %0d", v0_phase, 256 * f);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    logic [PHASE_W-1:0] want [3];
    want[0] = 17'h0FFFF; want[1] = 17'h1FFFE; want[2] = 17'h0FFFD;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      attr[v] = $urandom;
      attr[v][16] = 1'b1;
    end
    attr[5] = 32'h0001_FFFF;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      finish_frame(1'b0);
      vectors++;
      if (v5_phase !== want[f]) begin
        miscompares++; $display("FAIL wrap_v5: got %h required %h", v5_phase, want[f]);
      end
    end
  endtask

  task automatic test_stall();
    exp_t snap;
    int n = 0;
    start_frame();
    while (!(bus.ram_rd_en_o && bus.ram_rd_addr_o == 4'd3) && n < 100) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1 bus.voice_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 vectors++;
      if (i == 0) begin
        snap = cur_out();
        if (!bus.voice_valid_o || snap.idx !== 4'd3) begin
          miscompares++;
          $display("FAIL stall_enter: got valid=%0b idx=%0d required 1 3", bus.voice_valid_o, snap.idx);
        end
      end else if (!bus.voice_valid_o || cur_out() !== snap || bus.ram_rd_en_o) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%0b rd=%0b %h required 1 0 %h",
                 bus.voice_valid_o, bus.ram_rd_en_o, cur_out(), snap);
      end
    end
    bus.voice_ready_i = 1'b1;
    finish_frame(1'b0);
    vectors++;
    if (done_cyc - t0 != 58 || stall_cnt - stall0 != 10) begin
      miscompares++;
      $display("FAIL stall_len: got len=%0d stalls=%0d required 58 10", done_cyc - t0, stall_cnt - stall0);
    end
  endtask

  task automatic test_overrun();
    int ovr0;
    ovr0 = ovr_cnt;
    start_frame();
    while (cyc < t0 + 20) begin @(posedge clk); #1; end
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    finish_frame(1'b0);
    vectors++;
    if (ovr_cnt - ovr0 != 1 || ovr_cyc != t0 + 21) begin
      miscompares++;
      $display("FAIL overrun_mid: got n=%0d at %0d required 1 at %0d", ovr_cnt - ovr0, ovr_cyc - t0, 21);
    end
    // start coincident with the final handshake
    ovr0 = ovr_cnt;
    start_frame();
    while (cyc < t0 + exp_len) begin @(posedge clk); #1; end
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    finish_frame(1'b0);
    vectors++;
    if (ovr_cnt - ovr0 != 1 || ovr_cyc != t0 + exp_len + 1) begin
      miscompares++;
      $display("FAIL overrun_end: got n=%0d at %0d required 1 at %0d", ovr_cnt - ovr0, ovr_cyc - t0, exp_len + 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 vectors++;
      if (bus.busy_o !== 1'b0 || bus.ram_rd_en_o !== 1'b0) begin
        miscompares++;
        $display("FAIL overrun_norestart: got busy=%0b rd=%0b required 0 0", bus.busy_o, bus.ram_rd_en_o);
      end
    end
  endtask

  task automatic test_abort();
    int ovr0;
    start_frame();
    while (cyc < t0 + 30) begin @(posedge clk); #1; end
    rst = 1'b1; bus.start_i = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.start_i = 1'b0;
    clear_model();
    ovr0 = ovr_cnt;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.voice_valid_o !== 1'b0 || bus.voice_phase_o !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%0b valid=%0b phase=%h required 0 0 0",
               bus.busy_o, bus.voice_valid_o, bus.voice_phase_o);
    end
    repeat (60) @(posedge clk);
    #1 vectors++;
    if (done_cnt != done0 || ovr_cnt != ovr0) begin
      miscompares++;
      $display("FAIL abort_pulses: got done=%0d ovr=%0d required 0 0", done_cnt - done0, ovr_cnt - ovr0);
    end
    start_frame();
    finish_frame(1'b0);
    vectors++;
    if (v0_phase !== PHASE_W'(attr[0][15:0])) begin
      miscompares++; $display("FAIL abort_restart: got %h required %h", v0_phase, attr[0][15:0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 0; v < 16; v++) begin
      attr[v] = $urandom;
      attr[v][17] = 1'b1;
    end
    attr[2][21:16]  = 6'd0;
    attr[15][21:16] = 6'd0;
    for (int f = 0; f < 4; f++) begin
      start_frame();
      finish_frame(f >= 2);
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.voice_ready_i = 1'b1;
    for (int v = 0; v < 16; v++) attr[v] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish within budget");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/audio_voice_sequencer.md
AUDIO_VOICE_SEQUENCER -- requirements
Module: audio_voice_sequencer

Interface
REQ-001 Parameter: PHASE_W, default 17, width of each voice phase accumulator; legal values 16..24.
REQ-002 Port: clk, input, 1, single clock for all logic.
REQ-003 Port: rst, input, 1, reset; synchronous, active-high.
REQ-004 Port: start_i, input, 1, one-cycle pulse that starts a frame (one pass over voices 0..15).
REQ-005 Port: busy_o, output, 1, high from the cycle after an accepted start_i until frame end.
REQ-006 Port: ram_rd_en_o, output, 1, attribute RAM read enable.
REQ-007 Port: ram_rd_addr_o, output, 4, attribute RAM word address (voice index).
REQ-008 Port: ram_rd_data_i, input, 32, attribute word; valid exactly 1 cycle after the read request.
REQ-009 Port: voice_valid_o / voice_ready_i, output / input, 1 / 1, downstream handshake.
REQ-010 Port: voice_idx_o, output, 4, voice index of the presented result.
REQ-011 Port: voice_phase_o, output, PHASE_W, updated phase of that voice.
REQ-012 Port: voice_vol_o, voice_lr_o, voice_wave_o, voice_pw_o, output, 6/2/2/6, fields of the captured attribute word.
REQ-013 Port: frame_done_o and overrun_o, output, 1 each, one-cycle pulses.

Function
REQ-014 Attribute word layout SHALL be: [15:0] freq; [21:16] vol; [23:22] lr; [29:24] pw; [31:30] wave.
REQ-015 States SHALL be IDLE, READ, WAIT, EMIT.
REQ-016 IDLE: start_i=1 -> READ with voice counter=0; otherwise remain in IDLE.
REQ-017 READ: ram_rd_en_o=1 and ram_rd_addr_o=counter for exactly this cycle; next state WAIT. ram_rd_en_o SHALL be 0 in every other state.
REQ-018 WAIT: next state EMIT. On the WAIT->EMIT edge, capture ram_rd_data_i and write phase[counter] <= phase[counter] + zero-extended freq, modulo 2^PHASE_W.
REQ-019 EMIT: voice_valid_o=1, holding stable outputs (the new phase value and the captured fields) until the cycle where voice_ready_i=1.
REQ-020 EMIT with voice_ready_i=1: if counter=15, go to IDLE and pulse frame_done_o the same cycle; otherwise increment counter and go to READ.
REQ-021 Timing: minimum frame length is 48 cycles with voice_ready_i tied high; each stall cycle adds one cycle.
REQ-022 start_i while busy_o=1 SHALL be ignored (frame not restarted) and SHALL pulse overrun_o the next cycle.
REQ-023 start_i in the same cycle as the final EMIT handshake SHALL count as an overrun and SHALL NOT start a frame.
REQ-024 The phase array SHALL be 16 x PHASE_W registers internal to the block. Each phase SHALL update only once per frame, in its own WAIT cycle.
REQ-025 voice_valid_o SHALL NOT drop without a handshake; output fields SHALL NOT change while voice_valid_o=1 and voice_ready_i=0.

Reset
REQ-026 When rst=1 at a clock edge: state=IDLE, counter=0, all phases=0, all outputs=0, captured fields=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no frame_done_o pulse. A start_i coincident with rst SHALL be ignored.

Configuration
REQ-028 Macro AUDIO_SEQ_SKIP_MUTED_EN: when defined, a voice with vol=0 SHALL still have its phase updated. It SHALL skip EMIT (WAIT goes directly to READ, or to IDLE with frame_done_o if counter=15) and never assert voice_valid_o.
REQ-029 When AUDIO_SEQ_SKIP_MUTED_EN is undefined, every voice SHALL be emitted regardless of vol.

Verification
REQ-030 All attribute words=0x0000_0100 (freq=256), voice_ready_i=1, 3 frames -> 16 handshakes per frame, idx 0..15 in order, phase 256/512/768, frame_done_o at cycle 48 of each frame.
REQ-031 Voice 5 freq=0xFFFF, PHASE_W=17, 3 frames -> voice 5 phases 0x0FFFF, 0x1FFFE, 0x0FFFD (wrap).
REQ-032 voice_ready_i low 10 cycles during voice 3 EMIT -> outputs stable throughout, frame length 58 cycles, no read issued during the stall.
REQ-033 start_i pulsed at cycle 20 of a frame -> overrun_o pulse at cycle 21, frame completes normally, exactly one frame_done_o.
REQ-034 rst at cycle 30 of a frame, then start_i -> voice 0 phase restarts from freq and no frame_done_o for the aborted frame.
REQ-035 With AUDIO_SEQ_SKIP_MUTED_EN defined and voices 2 and 15 at vol=0 -> 14 handshakes per frame, phases of voices 2 and 15 still advance, frame_done_o after the voice 15 WAIT.
